// File: rtl/shr_pkg.sv
// Shared definitions for the multi-cycle right shifter: FSM state encoding and default sizes.
package shr_pkg;

    localparam int SHR_WIDTH = 32;
    localparam int SHR_SW    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shr_unit.sv
// Iterative right shifter: one bit per cycle, logical or arithmetic fill.
// Arithmetic (sign) fill exists only when SHR_SRA_EN is defined; otherwise every shift is logical.
module shr_unit
    import shr_pkg::*;
#(
    parameter int WIDTH = SHR_WIDTH,
    parameter int SW    = SHR_SW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             arith,
    input  logic [SW-1:0]    shamt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [SW-1:0]    r_count;
    logic             r_sign;
    logic [WIDTH-1:0] r_dout;
    logic             w_fill_sign;

`ifdef SHR_SRA_EN
    assign w_fill_sign = arith & din[WIDTH-1];
`else
    // arith stays on the interface but can never select sign fill
    assign w_fill_sign = arith & 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_count == SW'(1)) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_sign  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift <= din;
                        r_count <= shamt;
                        r_sign  <= w_fill_sign;
                    end
                end
                SHIFT: begin
                    r_shift <= {r_sign, r_shift[WIDTH-1:1]};
                    r_count <= r_count - SW'(1);
                end
                DONE:    r_dout <= r_shift;
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    // Result is forwarded during DONE so it is valid alongside the done pulse, then held.
    assign dout = (r_state == DONE) ? r_shift : r_dout;

endmodule

// File: tb/tb_shr_unit.sv
// Directed + short random bench for shr_unit with a scoreboard of expected results and latencies.
module tb_shr_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        arith;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int checks;
    int errors;
    int cyc;
    int acc_cyc;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];

    shr_unit #(.WIDTH(32), .SW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .arith (arith),
        .shamt (shamt),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_shift(logic [31:0] d, logic [4:0] s, logic a);
        logic [31:0] r;
        r = d >> s;
`ifdef SHR_SRA_EN
        if (a) r = $signed(d) >>> s;
`else
        if (a) r = d >> s;
`endif
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called positioned at a negedge; the request is sampled on the next rising edge.
    task automatic start_op(string tag, logic [31:0] d, logic [4:0] s, logic a);
        exp_t e;
        start = 1'b1;
        din   = d;
        shamt = s;
        arith = a;
        e.res = exp_shift(d, s, a);
        e.lat = int'(s);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start = 1'b0;
        din   = $urandom;
        shamt = 5'($urandom);
        arith = 1'($urandom);
        $display("op %s din=%h shamt=%0d arith=%0b accepted at cycle %0d", tag, d, s, a, acc_cyc);
    endtask

    // Latency is counted in rising edges after the accepting edge (shamt=0 -> 0).
    task automatic wait_done();
        exp_t e;
        bit   found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        check({e.tag, "_done_seen"}, 32'(found), 32'd1);
        if (found) begin
            check({e.tag, "_dout"}, dout, e.res);
            check({e.tag, "_latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
            check({e.tag, "_busy_in_done"}, 32'(busy), 32'd1);
            $display("result %s dout=%h latency=%0d", e.tag, dout, cyc - acc_cyc);
        end
        @(negedge clk);
        check({e.tag, "_done_single"}, 32'(done), 32'd0);
        check({e.tag, "_busy_after"}, 32'(busy), 32'd0);
        check({e.tag, "_dout_held"}, dout, e.res);
    endtask

    initial begin
        int pulses;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        arith  = 1'b0;
        shamt  = '0;
        din    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dout", dout, 32'd0);

        // Start in the first cycle after reset release.
        rst = 1'b0;
        start_op("sra4", 32'h8000_0000, 5'd4, 1'b1);
        wait_done();
        start_op("srl4", 32'h8000_0000, 5'd4, 1'b0);
        wait_done();
        start_op("sh0", 32'h1234_5678, 5'd0, 1'b0);
        wait_done();
        start_op("sra31", 32'h8000_0000, 5'd31, 1'b1);
        wait_done();
        start_op("srl31", 32'h8000_0000, 5'd31, 1'b0);
        wait_done();

        // Second start while busy must be ignored.
        start_op("ignore", 32'hFFFF_0000, 5'd3, 1'b0);
        @(negedge clk);
        start = 1'b1;
        din   = 32'h1;
        shamt = 5'd1;
        arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore_no_extra_done", 32'(pulses), 32'd0);

        // Reset during the second SHIFT cycle of a shamt=8 operation.
        start_op("abort", 32'hA5A5_A5A5, 5'd8, 1'b0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b1;
        pulses = 0;
        @(negedge clk);
        if (done) pulses++;
        @(negedge clk);
        if (done) pulses++;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dout", dout, 32'd0);
        check("abort_no_pulse", 32'(pulses), 32'd0);
        rst = 1'b0;
        start_op("post_rst", 32'h0F0F_0F0F, 5'd1, 1'b0);
        wait_done();

        for (int k = 0; k < 6; k++) begin
            start_op($sformatf("rnd%0d", k), $urandom, 5'($urandom), 1'($urandom));
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
